pc_seq: RTL
===========

# pc_seq

Sequencer for the program counter: runs a fetch/execute loop against instruction memory. Each cycle it drives the PC's mode, halt and data inputs from the decoded control-flow request. It holds the PC frozen while fetches are outstanding, while halted and while in reset. It also polices the PC's single-entry return register so that call and return stay balanced. It sits between the decoder, the instruction-memory port and `pc`.

## Interface
- N, default from `pico` (`pico::N`), data/offset width.
- CNT_W, default 16, width of the retired-instruction counter.
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- run_i  in  1  starts or resumes execution from IDLE or HALTED.
- halt_req_i  in  1  external halt request.
- imem_valid_i  in  1  instruction-memory response valid.
- br_i  in  1  decoded relative branch.
- call_i  in  1  decoded subroutine call.
- ret_i  in  1  decoded return.
- hlt_i  in  1  decoded halt instruction.
- off_i  in  N  branch offset or call target (signed).
- pc_mode_o  out  modePC  to `pc` `mode_i`.
- pc_halt_o  out  1  to `pc` `halt_i`.
- pc_data_o  out  N  to `pc` `data_i`.
- imem_req_o  out  1  fetch request.
- dec_en_o  out  1  decoded fields are being consumed this cycle.
- halted_o  out  1  in IDLE or HALTED.
- err_o  out  1  sticky call/return imbalance.
- instr_cnt_o  out  CNT_W  retired-instruction count.

## Operation
- States:
  - IDLE is the reset state.
  - FETCH, EXEC and HALTED are the other states.
- IDLE/HALTED:
  - pc_halt_o=1 and halted_o=1.
  - run_i=1 moves to FETCH.
- FETCH:
  - imem_req_o=1 and pc_halt_o=1.
  - imem_valid_i=1 moves to EXEC.
  - halt_req_i=1 moves to HALTED, abandoning the fetch; the PC is unchanged.
- EXEC lasts exactly one cycle:
  - dec_en_o=1 and pc_halt_o=0.
  - instr_cnt_o increments, wrapping from all-ones to 0.
- Mode priority in EXEC:
  - hlt_i: INCREMENT, next state HALTED.
  - else ret_i: RETURN.
  - else call_i: SUBROUTINE.
  - else br_i: RELATIVE.
  - else INCREMENT.
- Next state after EXEC is FETCH. It is HALTED if hlt_i or halt_req_i is set; the EXEC PC update still completes.
- pc_data_o:
  - equals off_i in EXEC when the selected mode is RELATIVE or SUBROUTINE;
  - otherwise 0.
- pc_mode_o is INCREMENT outside EXEC; `pc` ignores it because halt is asserted.
- Depth flag (1 bit) tracks the PC's single return register:
  - set on an issued SUBROUTINE;
  - cleared on an issued RETURN.

## Timing
- Reset values:
  - state IDLE, pc_halt_o=1, imem_req_o=0, dec_en_o=0;
  - halted_o=1, err_o=0, instr_cnt_o=0, depth=0;
  - pc_mode_o=INCREMENT, pc_data_o=0.
- rst_i mid-operation returns to IDLE on the next edge, regardless of state.
- All outputs are registered-state decodes:
  - pc_data_o and pc_mode_o are combinational from state and the decoded inputs;
  - there is no extra latency.
- Minimum 2 cycles per instruction: FETCH with imem_valid_i already high, then EXEC. Each extra wait cycle adds 1.
- The decoded inputs (br_i, call_i, ret_i, hlt_i, off_i) are sampled only in EXEC; they are don't-care elsewhere.
- run_i and halt_req_i both high in IDLE/HALTED: halt wins and the state stays put.
- PC advances exactly once per EXEC and never in any other state.

## Configuration
- PC_SEQ_CALL_CHECK_EN defined:
  - call_i while depth=1 sets err_o and issues INCREMENT instead; depth is unchanged.
  - ret_i while depth=0 sets err_o and issues INCREMENT instead.
  - err_o is cleared only by rst_i.
- Not defined:
  - calls and returns are forwarded unconditionally;
  - the depth flag is not built;
  - err_o is tied to 0.

## Test plan
- Reset then run_i pulse, imem_valid_i held high, no decoded requests -> alternating FETCH/EXEC, pc_halt_o low every 2nd cycle, instr_cnt_o=4 after 8 cycles, PC address 4.
- imem_valid_i delayed 3 cycles per fetch -> pc_halt_o stays high for 3 extra cycles, instr_cnt_o unchanged during wait.
- EXEC with br_i=1 and off_i=-2 -> pc_mode_o=RELATIVE, pc_data_o=-2, PC moves back 2. Same cycle with call_i=1 and off_i=0x10 -> SUBROUTINE wins, PC=0x10.
- Call then ret -> PC returns to call address+1, err_o=0. With the macro: second call while depth=1 -> err_o=1, PC increments. Without the macro: PC jumps and err_o=0.
- hlt_i in EXEC -> PC +1, then HALTED with halted_o=1. run_i resumes from FETCH. halt_req_i during FETCH -> HALTED, PC unchanged.
- rst_i asserted in EXEC with call_i=1 -> next cycle IDLE, instr_cnt_o=0, err_o=0, pc_halt_o=1.

Source files
------------

// File: rtl/pc_seq.sv
// Program-counter sequencer: fetch/execute loop that drives pc mode/halt/data.
// Optional call/return balance checking is built when PC_SEQ_CALL_CHECK_EN is defined.

package pico;
   parameter int unsigned N = 8;

   typedef enum logic [1:0] {
      INCREMENT  = 2'd0,
      RELATIVE   = 2'd1,
      SUBROUTINE = 2'd2,
      RETURN     = 2'd3
   } modePC;
endpackage

module pc_seq #(
   parameter int unsigned N     = pico::N,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic             halt_req_i,
   input  logic             imem_valid_i,
   input  logic             br_i,
   input  logic             call_i,
   input  logic             ret_i,
   input  logic             hlt_i,
   input  logic [N-1:0]     off_i,
   output pico::modePC      pc_mode_o,
   output logic             pc_halt_o,
   output logic [N-1:0]     pc_data_o,
   output logic             imem_req_o,
   output logic             dec_en_o,
   output logic             halted_o,
   output logic             err_o,
   output logic [CNT_W-1:0] instr_cnt_o
);

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StExec,
      StHalted
   } state_e;

   state_e             state_q, state_d;
   logic               pc_halt_q, imem_req_q, dec_en_q, halted_q;
   logic [CNT_W-1:0]   cnt_q;
   pico::modePC        req_mode;
   logic               call_bad, ret_bad;

`ifdef PC_SEQ_CALL_CHECK_EN
   logic depth_q;
   logic err_q;
`endif

   // Decoded request priority: halt, return, call, branch, then plain increment.
   always_comb begin
      req_mode = pico::INCREMENT;
      if (hlt_i) begin
         req_mode = pico::INCREMENT;
      end else if (ret_i) begin
         req_mode = pico::RETURN;
      end else if (call_i) begin
         req_mode = pico::SUBROUTINE;
      end else if (br_i) begin
         req_mode = pico::RELATIVE;
      end
   end

   always_comb begin
      call_bad = 1'b0;
      ret_bad  = 1'b0;
`ifdef PC_SEQ_CALL_CHECK_EN
      // The pc holds a single return address, so nesting or underflow is refused.
      call_bad = (req_mode == pico::SUBROUTINE) && depth_q;
      ret_bad  = (req_mode == pico::RETURN) && !depth_q;
`endif
   end

   always_comb begin
      pc_mode_o = pico::INCREMENT;
      pc_data_o = '0;
      if (state_q == StExec && !call_bad && !ret_bad) begin
         pc_mode_o = req_mode;
         if (req_mode == pico::RELATIVE || req_mode == pico::SUBROUTINE) begin
            pc_data_o = off_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StHalted: begin
            if (!halt_req_i && run_i) state_d = StFetch;
         end
         StFetch: begin
            if (halt_req_i) begin
               state_d = StHalted;
            end else if (imem_valid_i) begin
               state_d = StExec;
            end
         end
         StExec: begin
            state_d = (hlt_i || halt_req_i) ? StHalted : StFetch;
         end
         default: state_d = StIdle;
      endcase
   end

   // Status outputs are registered decodes of the next state, so they track state_q exactly.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         pc_halt_q  <= 1'b1;
         imem_req_q <= 1'b0;
         dec_en_q   <= 1'b0;
         halted_q   <= 1'b1;
         cnt_q      <= '0;
`ifdef PC_SEQ_CALL_CHECK_EN
         depth_q    <= 1'b0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_halt_q  <= (state_d != StExec);
         imem_req_q <= (state_d == StFetch);
         dec_en_q   <= (state_d == StExec);
         halted_q   <= (state_d == StIdle) || (state_d == StHalted);
         if (state_q == StExec) begin
            cnt_q <= cnt_q + CNT_W'(1);
`ifdef PC_SEQ_CALL_CHECK_EN
            if (call_bad || ret_bad) err_q <= 1'b1;
            if (pc_mode_o == pico::SUBROUTINE) begin
               depth_q <= 1'b1;
            end else if (pc_mode_o == pico::RETURN) begin
               depth_q <= 1'b0;
            end
`endif
         end
      end
   end

   assign pc_halt_o   = pc_halt_q;
   assign imem_req_o  = imem_req_q;
   assign dec_en_o    = dec_en_q;
   assign halted_o    = halted_q;
   assign instr_cnt_o = cnt_q;

`ifdef PC_SEQ_CALL_CHECK_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
